// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_pkg
// Purpose  : Shared types and encodings for the debug run monitor: FSM state
//            enum, halt-cause codes, dump index width, cause priority helper.
// Revision : 1.0 - initial release
// ============================================================================
package debug_pkg;

  // Run-control FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STEP     = 3'd2,
    ST_DUMP_RF  = 3'd3,
    ST_DUMP_MEM = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Halt-cause encodings reported on halt_cause
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_USER  = 2'd3;

  // Width of the dump index presented on dump_idx
  localparam int DUMP_IDX_W = 16;

  // Resolve simultaneous halt conditions: user beats breakpoint beats limit
  function automatic logic [1:0] halt_cause_sel(input logic user,
                                                input logic bp,
                                                input logic limit);
    logic [1:0] cause;
    cause = CAUSE_NONE;
    if (user) begin
      cause = CAUSE_USER;
    end else if (bp) begin
      cause = CAUSE_BP;
    end else if (limit) begin
      cause = CAUSE_LIMIT;
    end
    return cause;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dump_sequencer
// Purpose  : Streams the register file then a window of data memory out over
//            a valid/ready port. Owns the word index, the debug read
//            addresses and the last-word flag; the phase inputs come from the
//            run-control FSM in the top.
// Revision : 1.0 - initial release
// ============================================================================
module dump_sequencer
  import debug_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              NUM_REGS   = 32,
  parameter int              DUMP_WORDS = 5,
  parameter logic [XLEN-1:0] MEM_BASE   = '0,
  parameter int              RA_W       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rf_phase,
  input  logic                  mem_phase,
  input  logic                  dump_ready,
  input  logic [XLEN-1:0]       dbg_rf_data,
  input  logic [XLEN-1:0]       dbg_mem_data,
  output logic [RA_W-1:0]       dbg_rf_addr,
  output logic [XLEN-1:0]       dbg_mem_addr,
  output logic                  dump_valid,
  output logic [XLEN-1:0]       dump_data,
  output logic                  dump_is_mem,
  output logic [DUMP_IDX_W-1:0] dump_idx,
  output logic                  dump_last,
  output logic                  rf_done,
  output logic                  mem_done
);

  localparam logic [DUMP_IDX_W-1:0] C_RF_LAST = DUMP_IDX_W'(NUM_REGS - 1);

  logic [DUMP_IDX_W-1:0] r_idx;
  logic                  w_accept;
  logic                  w_rf_end;
  logic                  w_mem_end;

  // Everything presented is a function of r_idx and the phase, so while the
  // consumer stalls the word stays put (the CPU is frozen during a dump).
  assign dump_valid  = rf_phase | mem_phase;
  assign w_accept    = dump_valid & dump_ready;
  assign w_rf_end    = rf_phase & (r_idx == C_RF_LAST);
  assign dump_is_mem = mem_phase;
  assign dump_idx    = dump_valid ? r_idx : '0;
  assign dump_data   = mem_phase ? dbg_mem_data : (rf_phase ? dbg_rf_data : '0);
  assign dbg_rf_addr = rf_phase ? r_idx[RA_W-1:0] : '0;
  assign dbg_mem_addr = mem_phase ? (MEM_BASE + XLEN'({r_idx, 2'b00})) : '0;

  generate
    if (DUMP_WORDS == 0) begin : g_no_mem
      // No memory window: the final register word closes the stream
      assign w_mem_end = 1'b0;
      assign dump_last = w_rf_end;
    end else begin : g_mem
      localparam logic [DUMP_IDX_W-1:0] C_MEM_LAST = DUMP_IDX_W'(DUMP_WORDS - 1);
      assign w_mem_end = mem_phase & (r_idx == C_MEM_LAST);
      assign dump_last = w_mem_end;
    end
  endgenerate

  assign rf_done  = w_accept & w_rf_end;
  assign mem_done = w_accept & w_mem_end;

  // Word index: advances per accepted word, rewinds at each phase end and
  // whenever no dump is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (!dump_valid) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_idx <= (w_rf_end | w_mem_end) ? '0 : r_idx + DUMP_IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : debug_run_monitor
// Purpose  : Run control for a CPU under debug: free-run or single-step with
//            cycle limit, breakpoint and user halt, then a register-file and
//            data-memory dump through dump_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module debug_run_monitor
  import debug_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              NUM_REGS   = 32,
  parameter int              DUMP_WORDS = 5,
  parameter logic [XLEN-1:0] MEM_BASE   = '0,
  parameter int              CYCLE_W    = 16,
  localparam int             RA_W       = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               halt_req,
  input  logic [CYCLE_W-1:0] cycle_limit,
  input  logic               bp_en,
  input  logic [XLEN-1:0]    bp_addr,
  input  logic [XLEN-1:0]    pc,
  output logic               cpu_en,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [RA_W-1:0]    dbg_rf_addr,
  input  logic [XLEN-1:0]    dbg_rf_data,
  output logic [XLEN-1:0]    dbg_mem_addr,
  input  logic [XLEN-1:0]    dbg_mem_data,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [XLEN-1:0]    dump_data,
  output logic               dump_is_mem,
  output logic [15:0]        dump_idx,
  output logic               dump_last
);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_step_d;
  logic               r_first;
  logic [CYCLE_W-1:0] r_count;
  logic [CYCLE_W-1:0] w_count_inc;
  logic [1:0]         r_cause;
  logic               w_start_ok;
  logic               w_step_rise;
  logic               w_slot;
  logic               w_user;
  logic               w_bp;
  logic               w_limit;
  logic               w_halt;
  logic               w_rf_phase;
  logic               w_mem_phase;
  logic               w_rf_done;
  logic               w_mem_done;

  // Start is honoured only from IDLE or DONE; elsewhere it is ignored
  assign w_start_ok  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_step_rise = step & ~r_step_d;
  // Saturating increment: the counter sticks at all-ones
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CYCLE_W'(1);

  assign cycle_count = r_count;
  assign halt_cause  = r_cause;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = step_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        if (w_halt) w_next_state = ST_DUMP_RF;
      end
      ST_DUMP_RF: begin
        if (w_rf_done) w_next_state = (DUMP_WORDS == 0) ? ST_DONE : ST_DUMP_MEM;
      end
      ST_DUMP_MEM: begin
        if (w_mem_done) w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs and halt detection; user and breakpoint halts veto the cycle,
  // the limit halt lets the final counted cycle execute
  always_comb begin
    w_slot      = 1'b0;
    w_user      = 1'b0;
    w_bp        = 1'b0;
    w_limit     = 1'b0;
    w_halt      = 1'b0;
    cpu_en      = 1'b0;
    halted      = 1'b0;
    w_rf_phase  = 1'b0;
    w_mem_phase = 1'b0;
    unique case (r_state)
      ST_RUN:      w_slot = 1'b1;
      ST_STEP:     w_slot = w_step_rise;
      ST_DUMP_RF:  w_rf_phase = 1'b1;
      ST_DUMP_MEM: w_mem_phase = 1'b1;
      ST_DONE:     halted = 1'b1;
      default:     w_slot = 1'b0;
    endcase
    w_user  = ((r_state == ST_RUN) || (r_state == ST_STEP)) && halt_req;
    // The first enabled cycle after start skips the breakpoint so a run can
    // resume from the PC it last stopped on
    w_bp    = w_slot && bp_en && (pc == bp_addr) && !r_first;
    cpu_en  = w_slot && !w_user && !w_bp;
    w_limit = cpu_en && (cycle_limit != '0) && (w_count_inc == cycle_limit);
    w_halt  = w_user || w_bp || w_limit;
  end

  // Step edge detector history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  // Cycle counter, halt cause and first-cycle flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_cause <= CAUSE_NONE;
      r_first <= 1'b0;
    end else if (w_start_ok) begin
      r_count <= '0;
      r_cause <= CAUSE_NONE;
      r_first <= 1'b1;
    end else begin
      if (cpu_en) begin
        r_count <= w_count_inc;
        r_first <= 1'b0;
      end
      if (w_halt) begin
        r_cause <= halt_cause_sel(w_user, w_bp, w_limit);
      end
    end
  end

  dump_sequencer #(
    .XLEN       (XLEN),
    .NUM_REGS   (NUM_REGS),
    .DUMP_WORDS (DUMP_WORDS),
    .MEM_BASE   (MEM_BASE),
    .RA_W       (RA_W)
  ) u_dump_sequencer (
    .clk          (clk),
    .rst_n        (rst_n),
    .rf_phase     (w_rf_phase),
    .mem_phase    (w_mem_phase),
    .dump_ready   (dump_ready),
    .dbg_rf_data  (dbg_rf_data),
    .dbg_mem_data (dbg_mem_data),
    .dbg_rf_addr  (dbg_rf_addr),
    .dbg_mem_addr (dbg_mem_addr),
    .dump_valid   (dump_valid),
    .dump_data    (dump_data),
    .dump_is_mem  (dump_is_mem),
    .dump_idx     (dump_idx),
    .dump_last    (dump_last),
    .rf_done      (w_rf_done),
    .mem_done     (w_mem_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_run_monitor
// Purpose  : Self-checking bench for debug_run_monitor: vector table, random
//            run scenarios against a reference model, step/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_run_monitor;

  localparam int              XLEN       = 32;
  localparam int              NUM_REGS   = 32;
  localparam int              DUMP_WORDS = 5;
  localparam int              CYCLE_W    = 8;
  localparam int              RA_W       = 5;
  localparam logic [XLEN-1:0] MEM_BASE   = '0;
  localparam int              INF        = 1 << 30;
  localparam int              CNT_MAX    = (1 << CYCLE_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               step_mode;
  logic               step;
  logic               halt_req;
  logic [CYCLE_W-1:0] cycle_limit;
  logic               bp_en;
  logic [XLEN-1:0]    bp_addr;
  logic [XLEN-1:0]    pc;
  logic               cpu_en;
  logic               halted;
  logic [1:0]         halt_cause;
  logic [CYCLE_W-1:0] cycle_count;
  logic [RA_W-1:0]    dbg_rf_addr;
  logic [XLEN-1:0]    dbg_rf_data;
  logic [XLEN-1:0]    dbg_mem_addr;
  logic [XLEN-1:0]    dbg_mem_data;
  logic               dump_valid;
  logic               dump_ready;
  logic [XLEN-1:0]    dump_data;
  logic               dump_is_mem;
  logic [15:0]        dump_idx;
  logic               dump_last;

  debug_run_monitor #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DUMP_WORDS(DUMP_WORDS),
    .MEM_BASE(MEM_BASE), .CYCLE_W(CYCLE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
    .step(step), .halt_req(halt_req), .cycle_limit(cycle_limit),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_data(dbg_rf_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_is_mem(dump_is_mem), .dump_idx(dump_idx), .dump_last(dump_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU-side storage seen through the combinational debug read ports
  logic [XLEN-1:0] rf_mem [NUM_REGS];
  logic [XLEN-1:0] dmem   [8];
  assign dbg_rf_data  = rf_mem[dbg_rf_addr];
  assign dbg_mem_data = (dbg_mem_addr < 32'd32) ? dmem[dbg_mem_addr[4:2]] : 32'hBAD0_BAD0;

  typedef struct {
    logic [31:0] data;
    logic        is_mem;
    int          idx;
    logic        last;
    logic [31:0] addr;
  } word_t;

  typedef struct {
    int         limit;
    bit         bpe;
    int         bpa;
    int         pc0;
    int         h;
    int         rmode;
    int         exp_n;
    logic [1:0] exp_cause;
  } vec_t;

  word_t       exp_q[$];
  vec_t        tbl[9];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt;
  int          words;
  bit          mon_en;
  bit          stalled;
  logic [31:0] p_data;
  logic [15:0] p_idx;
  logic        p_is_mem;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within budget", name);
  endtask

  // One clock: observe at the falling edge, then let the CPU model advance
  task automatic tick();
    logic  en;
    word_t e;
    @(negedge clk);
    en = cpu_en;
    if (en) en_cnt++;
    if (mon_en) begin
      if (dump_valid) chk("cpu_en_in_dump", cpu_en, 0);
      if (stalled) begin
        chk("stall_valid", dump_valid, 1);
        chk("stall_data", dump_data, p_data);
        chk("stall_idx", dump_idx, p_idx);
        chk("stall_is_mem", dump_is_mem, p_is_mem);
      end
      stalled  = dump_valid && !dump_ready;
      p_data   = dump_data;
      p_idx    = dump_idx;
      p_is_mem = dump_is_mem;
      if (dump_valid && dump_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL extra_word: got idx %0d expected no word", dump_idx);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", dump_data, e.data);
          chk("word_is_mem", dump_is_mem, e.is_mem);
          chk("word_idx", dump_idx, e.idx);
          chk("word_last", dump_last, e.last);
          chk("word_addr", e.is_mem ? dbg_mem_addr : 32'(dbg_rf_addr), e.addr);
        end
      end
    end
    @(posedge clk);
    #1;
    if (en) pc = pc + 32'd4;
  endtask

  // Fresh CPU contents and the stream the dump must reproduce from them
  task automatic build_stream();
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_mem[i] = $urandom;
      exp_q.push_back('{rf_mem[i], 1'b0, i, 1'b0, 32'(i)});
    end
    for (int j = 0; j < 8; j++) dmem[j] = $urandom;
    for (int j = 0; j < DUMP_WORDS; j++)
      exp_q.push_back('{dmem[j], 1'b1, j, (j == DUMP_WORDS - 1), MEM_BASE + 32'(4 * j)});
  endtask

  // Reference: each halt source fires at a known run-cycle index; the
  // earliest wins, same-cycle ties go user > breakpoint > limit
  task automatic model(input int limit, input bit bpe, input int bpa, input int pc0,
                       input int h, output int n, output logic [1:0] cause);
    int k;
    int lc;
    k = INF;
    if (bpe && bpa > pc0 && ((bpa - pc0) % 4) == 0) k = (bpa - pc0) / 4;
    lc = (limit == 0) ? INF : limit - 1;
    if (h <= k && h <= lc) begin
      n = h; cause = 2'd3;
    end else if (k <= lc) begin
      n = k; cause = 2'd2;
    end else begin
      n = limit; cause = 2'd1;
    end
  endtask

  // Free-run scenario: start, user halt from run cycle h onward, drain dump
  task automatic run_case(input string tag, input int limit, input bit bpe, input int bpa,
                          input int pc0, input int h, input int rmode,
                          input int exp_n, input logic [1:0] exp_cause);
    int r;
    bit done;
    build_stream();
    pc = 32'(pc0); cycle_limit = CYCLE_W'(limit); bp_en = bpe; bp_addr = 32'(bpa);
    step_mode = 1'b0; step = 1'b0; halt_req = 1'b0; dump_ready = 1'b0;
    en_cnt = 0; words = 0; stalled = 1'b0; mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    r = 0;
    done = 1'b0;
    while (!done && r < 3000) begin
      halt_req   = (h != INF) && (r >= h);
      dump_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (r % 2 == 0) : 1'($urandom_range(0, 1));
      tick();
      r++;
      done = halted;
    end
    if (!done) fail_now({tag, ".timeout"});
    halt_req = 1'b0; dump_ready = 1'b0;
    chk({tag, ".en_cycles"}, en_cnt, exp_n);
    chk({tag, ".cycle_count"}, cycle_count, (exp_n > CNT_MAX) ? CNT_MAX : exp_n);
    chk({tag, ".cause"}, halt_cause, exp_cause);
    chk({tag, ".words"}, words, NUM_REGS + DUMP_WORDS);
    chk({tag, ".leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    int          n;
    logic [1:0]  c;
    int          lim, bpa, pc0, h, rm;
    bit          bpe;
    bit          hit;
    logic [14:0] step_pat;

    tbl[0] = '{10, 1'b0, 0,     0,     INF, 0, 10, 2'd1};
    tbl[1] = '{0,  1'b1, 'h0C,  0,     INF, 0, 3,  2'd2};
    tbl[2] = '{0,  1'b1, 'h0C,  0,     3,   1, 3,  2'd3};
    tbl[3] = '{4,  1'b1, 'h10,  0,     INF, 2, 4,  2'd1};
    tbl[4] = '{6,  1'b1, 'h20,  'h20,  INF, 0, 6,  2'd1};
    tbl[5] = '{5,  1'b0, 0,     0,     0,   1, 0,  2'd3};
    tbl[6] = '{1,  1'b0, 0,     0,     INF, 0, 1,  2'd1};
    tbl[7] = '{3,  1'b1, 'h08,  0,     2,   0, 2,  2'd3};
    tbl[8] = '{3,  1'b1, 'h0C,  0,     INF, 2, 3,  2'd1};

    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
    cycle_limit = '0; bp_en = 1'b0; bp_addr = '0; pc = '0; dump_ready = 1'b0;
    mon_en = 1'b0; stalled = 1'b0; en_cnt = 0; words = 0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;
    for (int j = 0; j < 8; j++) dmem[j] = '0;
    #12;
    chk("rst.cpu_en", cpu_en, 0);
    chk("rst.halted", halted, 0);
    chk("rst.cause", halt_cause, 0);
    chk("rst.count", cycle_count, 0);
    chk("rst.valid", dump_valid, 0);
    chk("rst.last", dump_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("idle.cpu_en", cpu_en, 0);

    // Vector table
    for (int i = 0; i < 9; i++)
      run_case($sformatf("vec%0d", i), tbl[i].limit, tbl[i].bpe, tbl[i].bpa, tbl[i].pc0,
               tbl[i].h, tbl[i].rmode, tbl[i].exp_n, tbl[i].exp_cause);

    // Random free-run scenarios against the reference model
    for (int t = 0; t < 20; t++) begin
      lim = $urandom_range(0, 20);
      bpe = 1'($urandom_range(0, 1));
      pc0 = 4 * $urandom_range(0, 8);
      bpa = 4 * $urandom_range(0, 20) + (($urandom_range(0, 5) == 0) ? 2 : 0);
      h   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : INF;
      rm  = $urandom_range(0, 2);
      if (lim == 0 && h == INF) lim = $urandom_range(1, 15);
      model(lim, bpe, bpa, pc0, h, n, c);
      run_case($sformatf("rnd%0d", t), lim, bpe, bpa, pc0, h, rm, n, c);
    end

    // Counter saturation: 300 executed cycles on an 8-bit counter
    model(0, 1'b0, 0, 0, 300, n, c);
    run_case("sat", 0, 1'b0, 0, 0, 300, 0, n, c);

    // Single-step: rising edges at positions 1, 4 and 11; 4..7 is one held step
    build_stream();
    step_pat = 15'b000_1000_1111_0010;
    pc = '0; cycle_limit = '0; bp_en = 1'b0; step_mode = 1'b1; dump_ready = 1'b0;
    en_cnt = 0; words = 0; stalled = 1'b0; mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step = step_pat[i];
      tick();
    end
    step = 1'b0;
    tick();
    chk("step.en_cycles", en_cnt, 3);
    chk("step.count", cycle_count, 3);
    chk("step.pc", pc, 32'h0C);
    halt_req = 1'b1; dump_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = halted;
    end
    if (!hit) fail_now("step.timeout");
    halt_req = 1'b0; step_mode = 1'b0;
    chk("step.cause", halt_cause, 3);
    chk("step.words", words, NUM_REGS + DUMP_WORDS);

    // Reset in the middle of the memory dump
    build_stream();
    pc = '0; cycle_limit = CYCLE_W'(2); bp_en = 1'b0; halt_req = 1'b0; dump_ready = 1'b1;
    en_cnt = 0; words = 0; stalled = 1'b0; mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      hit = dump_is_mem && (dump_idx == 16'd2);
    end
    if (!hit) fail_now("rstdump.reach");
    chk("rstdump.pre_valid", dump_valid, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstdump.cpu_en", cpu_en, 0);
    chk("rstdump.halted", halted, 0);
    chk("rstdump.cause", halt_cause, 0);
    chk("rstdump.count", cycle_count, 0);
    chk("rstdump.valid", dump_valid, 0);
    chk("rstdump.last", dump_last, 0);
    chk("rstdump.idx", dump_idx, 0);
    chk("rstdump.rf_addr", dbg_rf_addr, 0);
    chk("rstdump.mem_addr", dbg_mem_addr, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstdump.quiet", dump_valid, 0);
    end
    run_case("rerun", 3, 1'b0, 0, 0, INF, 0, 3, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
